// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset value
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with one-entry holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    input  logic                      uart_sel,
    input  logic                      rd_en,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_IDX  = 3'(UART_DATA_BITS - 1);

    rx_state_t                 state;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      rx_s;
    logic                      read;
    logic                      stop_sample;

    sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign read        = uart_sel & rd_en;
    assign stop_sample = (state == STOP) && (cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is high again at mid-bit was only a glitch
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // A read in the stop-sample cycle frees the holding register for the new byte
            if (stop_sample) begin
                if (!rx_valid || read) begin
                    rx_data   <= shreg;
                    rx_valid  <= 1'b1;
                    frame_err <= ~rx_s;
                    if (read) begin
                        overrun <= 1'b0;
                    end
                end else begin
                    overrun <= 1'b1;
                end
            end else if (read) begin
                rx_valid  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       uart_sel;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .uart_sel  (uart_sel),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(16);
    endtask

    // Start bit and 8 data bits, then leave rx at the stop level; returns 144 edges after start
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        rx = stop_lvl;
    endtask

    task automatic do_read();
        uart_sel = 1'b1;
        rd_en    = 1'b1;
        tick(1);
        uart_sel = 1'b0;
        rd_en    = 1'b0;
    endtask

    initial begin
        logic [7:0] partial;
        rst = 1'b1; rx = 1'b1; uart_sel = 1'b0; rd_en = 1'b0;
        tick(3);
        rst = 1'b0;
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        tick(5);

        // 8'hA5, good stop: stop sample at edge 3+8+144 = 155 after start drive
        send_frame(8'hA5, 1'b1);
        tick(10);
        check("a5_valid_before", 32'(rx_valid), 32'h0);
        tick(1);
        check("a5_valid_rise", 32'(rx_valid), 32'h1);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_frame_err", 32'(frame_err), 32'h0);
        check("a5_overrun", 32'(overrun), 32'h0);
        tick(5);
        do_read();
        check("a5_read_clears", 32'(rx_valid), 32'h0);
        check("a5_data_held", 32'(rx_data), 32'hA5);

        // 4-cycle glitch
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_valid", 32'(rx_valid), 32'h0);
        check("glitch_frame_err", 32'(frame_err), 32'h0);
        check("glitch_overrun", 32'(overrun), 32'h0);

        // 8'h3C with stop held low for 40 cycles
        send_frame(8'h3C, 1'b0);
        tick(11);
        check("3c_valid", 32'(rx_valid), 32'h1);
        check("3c_data", 32'(rx_data), 32'h3C);
        check("3c_frame_err", 32'(frame_err), 32'h1);
        check("3c_overrun", 32'(overrun), 32'h0);
        tick(29);
        check("3c_wait_high", 32'(dut.state), 32'(WAIT_HIGH));
        rx = 1'b1;
        tick(40);
        check("3c_back_idle", 32'(dut.state), 32'(IDLE));
        check("3c_no_second_byte", 32'(overrun), 32'h0);
        check("3c_data_kept", 32'(rx_data), 32'h3C);
        do_read();
        check("3c_read_frame_err", 32'(frame_err), 32'h0);
        check("3c_read_valid", 32'(rx_valid), 32'h0);

        // 8'h11 then 8'h22 without a read -> overrun
        send_frame(8'h11, 1'b1);
        tick(16);
        send_frame(8'h22, 1'b1);
        tick(11);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_frame_err", 32'(frame_err), 32'h0);
        tick(5);
        do_read();
        check("ovr_read_valid", 32'(rx_valid), 32'h0);
        check("ovr_read_overrun", 32'(overrun), 32'h0);
        send_frame(8'h33, 1'b1);
        tick(11);
        check("ovr_next_data", 32'(rx_data), 32'h33);
        check("ovr_next_valid", 32'(rx_valid), 32'h1);
        tick(5);
        do_read();

        // 8'h55 then 8'h66 with a read in 8'h66's stop-sample cycle
        send_frame(8'h55, 1'b1);
        tick(16);
        send_frame(8'h66, 1'b1);
        tick(10);
        uart_sel = 1'b1;
        rd_en    = 1'b1;
        tick(1);
        uart_sel = 1'b0;
        rd_en    = 1'b0;
        check("rdacc_data", 32'(rx_data), 32'h66);
        check("rdacc_valid", 32'(rx_valid), 32'h1);
        check("rdacc_overrun", 32'(overrun), 32'h0);
        tick(5);

        // Reset in the middle of bit 4 of 8'hC3 (holding register still full with 8'h66)
        partial = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rx = partial[4];
        tick(8);
        rst = 1'b1;
        tick(1);
        check("rst_mid_data", 32'(rx_data), 32'h00);
        check("rst_mid_valid", 32'(rx_valid), 32'h0);
        check("rst_mid_frame_err", 32'(frame_err), 32'h0);
        check("rst_mid_overrun", 32'(overrun), 32'h0);
        check("rst_mid_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        rx  = 1'b1;
        tick(20);
        send_frame(8'hF0, 1'b1);
        tick(11);
        check("post_rst_data", 32'(rx_data), 32'hF0);
        check("post_rst_valid", 32'(rx_valid), 32'h1);
        check("post_rst_frame_err", 32'(frame_err), 32'h0);
        tick(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
